// File: rtl/gates_tester_pkg.sv
// Shared types and helpers for the 3-input gate device tester.
// Response bit layout and the golden gate equations live here.
package gates_tester_pkg;

  localparam int RESP_W = 5;

  localparam int RESP_AND  = 4;
  localparam int RESP_OR   = 3;
  localparam int RESP_NAND = 2;
  localparam int RESP_NOR  = 1;
  localparam int RESP_XOR  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Golden outputs of the gate device for input vector v = {a, b, c}.
  function automatic logic [RESP_W-1:0] expected_resp(input logic [2:0] v);
    logic a, b, c;
    logic [RESP_W-1:0] r;
    a = v[2];
    b = v[1];
    c = v[0];
    r = '0;
    r[RESP_AND]  = a & b & c;
    r[RESP_OR]   = a | b | c;
    r[RESP_NAND] = ~(a & b & c);
    r[RESP_NOR]  = ~(a | b | c);
    r[RESP_XOR]  = a ^ b ^ c;
    return r;
  endfunction

endpackage

// File: rtl/gates_tester_sync2.sv
// Parameterised-width two-flop synchronizer with synchronous active-high reset.
module gates_tester_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gates_tester.sv
// Walks all 8 {a,b,c} vectors onto the gate device and checks its 5 outputs.
// Define GATES_TESTER_STOP_ON_FAIL_EN to halt on the first mismatching vector.
module gates_tester
  import gates_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [2:0]        drv,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [3:0]        fail_count,
  output logic [7:0]        fail_mask,
  output logic [2:0]        first_fail,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // The settle window must cover the 2-flop sync plus device propagation.
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("gates_tester: SETTLE_CYCLES must be >= 3");
  end

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [RESP_W-1:0] resp_s;
  logic              mismatch;
  logic              last_vec;
  logic              settle_last;
  logic              stop_now;

  gates_tester_sync2 #(.W(RESP_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (resp),
    .q   (resp_s)
  );

  always_comb begin
    mismatch    = (resp_s != expected_resp(drv));
    last_vec    = (drv == 3'd7);
    settle_last = (cnt == CNT_LAST);
`ifdef GATES_TESTER_STOP_ON_FAIL_EN
    stop_now    = last_vec || mismatch;
`else
    stop_now    = last_vec;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // start is a level, only looked at in IDLE/DONE; while busy it is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)       state_nxt = SETTLE;
      SETTLE:     if (settle_last) state_nxt = CHECK;
      CHECK:      state_nxt = stop_now ? DONE : SETTLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SETTLE) || (state == CHECK);
    done      = (state == DONE);
    pass      = (state == DONE) && (fail_count == 4'd0);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drv        <= '0;
      cnt        <= '0;
      fail_count <= '0;
      fail_mask  <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            drv        <= '0;
            cnt        <= '0;
            fail_count <= '0;
            fail_mask  <= '0;
            first_fail <= '0;
          end
        end
        SETTLE: cnt <= cnt + CNT_W'(1);
        CHECK: begin
          if (mismatch) begin
            fail_count     <= fail_count + 4'd1;
            fail_mask[drv] <= 1'b1;
            if (fail_count == 4'd0) first_fail <= drv;
          end
          // On stop, drv stays put so the last (or failing) vector is held.
          if (!stop_now) begin
            drv <= drv + 3'd1;
            cnt <= '0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gates_tester.sv
// Bench for gates_tester: a behavioural gate device with injectable output faults
// drives the tester; results are predicted from the gate truth table and fault map.
module tb_gates_tester;
  import gates_tester_pkg::*;

  localparam int SETTLE = 4;
  localparam int PERIOD = SETTLE + 1;
  localparam int MAX_CYCLES = 200;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] drv;
  logic [4:0] resp;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_count;
  logic [7:0] fail_mask;
  logic [2:0] first_fail;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  // Per-vector XOR corruption applied to the golden device outputs.
  logic [4:0] corrupt [8];

  gates_tester #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .drv        (drv),
    .resp       (resp),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .fail_mask  (fail_mask),
    .first_fail (first_fail),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- device model ----------------
  function automatic logic [4:0] good_resp(input int v);
    logic g_and, g_or, g_xor;
    g_and = (v == 7);
    g_or  = (v != 0);
    g_xor = ($countones(v[2:0]) % 2) == 1;
    return {g_and, g_or, ~g_and, ~g_or, g_xor};
  endfunction

  always_comb resp = good_resp(int'(drv)) ^ corrupt[drv];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fault(input int mode);
    for (int v = 0; v < 8; v++) begin
      logic [4:0] g;
      g = good_resp(v);
      case (mode)
        1:       corrupt[v] = {g[4], 4'b0000};            // and stuck at 0
        2:       corrupt[v] = 5'b00001;                   // xor inverted
        3:       corrupt[v] = {3'b000, ~g[1], 1'b0};      // nor stuck at 1
        4:       corrupt[v] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        default: corrupt[v] = 5'd0;
      endcase
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_drv"},   32'(drv), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_pass"},  32'(pass), 0);
    check({tag, "_cnt"},   32'(fail_count), 0);
    check({tag, "_mask"},  32'(fail_mask), 0);
    check({tag, "_first"}, 32'(first_fail), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // Pulse start, follow the run cycle by cycle, then check the final results
  // against the scoreboard built from the fault map.
  task automatic run_check(input string tag, input int repulse_at);
    logic [31:0] exp_q[$];
    int exp_cnt, exp_ff, exp_len, exp_last, n;
    logic [7:0] exp_mask;
    exp_cnt = 0;
    exp_ff = 0;
    exp_mask = 8'h00;
    for (int v = 0; v < 8; v++) begin
      if (corrupt[v] != 5'd0) begin
        if (exp_cnt == 0) exp_ff = v;
        exp_cnt++;
        exp_mask[v] = 1'b1;
      end
    end
    exp_len = 8 * PERIOD;
    exp_last = 7;
`ifdef GATES_TESTER_STOP_ON_FAIL_EN
    if (exp_cnt != 0) begin
      exp_cnt = 1;
      exp_mask = 8'h01 << exp_ff;
      exp_len = (exp_ff + 1) * PERIOD;
      exp_last = exp_ff;
    end
`endif
    for (int i = 0; i < exp_len; i++) exp_q.push_back(32'(i / PERIOD));

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < MAX_CYCLES) begin
      start = (n == repulse_at);
      if (n == 0) begin
        check({tag, "_clr_cnt"},  32'(fail_count), 0);
        check({tag, "_clr_mask"}, 32'(fail_mask), 0);
        check({tag, "_clr_first"}, 32'(first_fail), 0);
        check({tag, "_clr_pass"}, 32'(pass), 0);
      end
      check({tag, "_busy"}, 32'(busy), 1);
      if (exp_q.size() != 0) check({tag, "_drv_seq"}, 32'(drv), exp_q.pop_front());
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_len"},   n, exp_len);
    check({tag, "_done"},  32'(done), 1);
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(DONE));
    check({tag, "_pass"},  32'(pass), (exp_cnt == 0) ? 1 : 0);
    check({tag, "_fcnt"},  32'(fail_count), exp_cnt);
    check({tag, "_mask"},  32'(fail_mask), 32'(exp_mask));
    check({tag, "_first"}, 32'(first_fail), exp_ff);
    check({tag, "_drv"},   32'(drv), exp_last);
    repeat (3) @(negedge clk);
    check({tag, "_hold_done"}, 32'(done), 1);
    check({tag, "_hold_mask"}, 32'(fail_mask), 32'(exp_mask));
    check({tag, "_hold_drv"},  32'(drv), exp_last);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    set_fault(0);
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("idle");

    run_check("golden", -1);
    set_fault(1);
    run_check("and_stuck0", -1);
    set_fault(2);
    run_check("xor_inv", -1);
    set_fault(3);
    run_check("nor_stuck1", -1);

    // Restart from DONE with stale failures, re-pulsing start mid-run.
    set_fault(0);
    run_check("repulse", 12);

    // Reset mid-run abandons everything.
    set_fault(2);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("midrun_rst");
    @(negedge clk);
    check_reset_values("post_rst");
    set_fault(0);
    run_check("after_rst", -1);

    for (int k = 0; k < 10; k++) begin
      set_fault(4);
      run_check($sformatf("rand%0d", k), (k % 3 == 0) ? int'($urandom_range(1, 30)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
